io64_uart_tx: RTL and testbench
===============================

Name: io64_uart_tx

Overview:
Output-port serializer sitting directly downstream of the CPU's IO64_OUT register. It detects every change of the 16-bit IO64_OUT value and buffers the new word in a small FIFO. It transmits each buffered word over a single-wire 8N1 UART line as two bytes, low byte first. This gives the bench and the board a serial observation point for program output without extra pins.

Parameters:
CLK_DIV, 16, clock cycles per UART bit time; legal range 2..65535.
DEPTH, 4, FIFO entries of 16-bit words; power of two, at least 2.
ADDR_W, 2, log2(DEPTH); FIFO pointer width.

Ports:
CLK  input  1  single system clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
IO64_OUT  input  16  CPU output-port value, sampled every clock.
TX  output  1  UART serial line; idle high.
TX_BUSY  output  1  high while a word is being transmitted (FSM not in IDLE).
FIFO_CNT  output  ADDR_W+1  number of words waiting in the FIFO.
OVERFLOW  output  1  sticky flag: a change was dropped because the FIFO was full.

Behaviour:
- Reset (RESET=1 at an edge), applied regardless of the current state:
  - TX=1, TX_BUSY=0, FIFO_CNT=0, OVERFLOW=0.
  - FSM=IDLE; FIFO pointers=0; shadow register PREV=16'h0000; bit and baud counters=0.
  - A frame in progress is abandoned. TX returns high on that edge.
- Change detect:
  - At each non-reset edge, if IO64_OUT != PREV, PREV<=IO64_OUT and a push is requested.
  - A value equal to PREV generates nothing.
  - The first nonzero value after reset counts as a change.
- Push:
  - Accepted when FIFO_CNT < DEPTH, with FIFO_CNT evaluated before any pop on the same edge.
  - When FIFO_CNT == DEPTH, the word is dropped and OVERFLOW<=1. This holds even if a pop occurs on the same edge.
  - PREV updates whether the word is accepted or dropped.
  - OVERFLOW clears only on reset.
- Pop: FSM in IDLE and FIFO_CNT != 0. The word is loaded into a 16-bit holding register; byte index=0; FSM->START.
- Simultaneous push and pop (FIFO not full): both occur and FIFO_CNT is unchanged.
- Pointers wrap modulo DEPTH.
- FIFO_CNT is registered and reflects pushes and pops at the same edge that performs them.
- Same-cycle push-then-pop is not allowed: a word pushed at edge n can be popped no earlier than edge n+1.
- FSM states (every bit time is exactly CLK_DIV clocks, counted by the baud counter):
  - IDLE: TX=1; TX_BUSY=0. Exits on pop.
  - START: TX=0 for one bit time, then ->DATA with bit counter=0.
  - DATA: TX = current byte bit[bit counter], LSB first; 8 bit times, then ->STOP.
  - STOP: TX=1 for one bit time. Then: if byte index==0, set byte index=1 and go ->START; else go ->IDLE.
- Byte order: byte 0 = word[7:0], byte 1 = word[15:8].
- Timing:
  - One word = 20 bit times = 20*CLK_DIV clocks from the pop edge to the return to IDLE.
  - Back-to-back words: the pop occurs on the edge after the IDLE entry, so there is exactly 1 idle-high clock between frames.
- Latency: IO64_OUT changes before edge n (FIFO empty, FSM idle) -> pushed at n -> popped at n+1 -> TX low and TX_BUSY high from edge n+1.
- TX is driven from a register (glitch-free).

Test Plan:
1. Reset, CLK_DIV=4; hold IO64_OUT=0 for 200 clocks -> TX stays 1, TX_BUSY=0, FIFO_CNT=0, no frame.
2. Set IO64_OUT=16'h1234 -> TX low at edge n+1; decoded bytes 0x34 then 0x12. Each bit lasts 4 clocks; stop bits high; TX_BUSY high for exactly 80 clocks.
3. Write 0x00AB, then 0x00AB again 10 clocks later -> exactly one two-byte frame (0xAB, 0x00).
4. DEPTH=4; change IO64_OUT on 6 consecutive clocks (values 1..6):
   - word 1 is popped immediately; words 2..5 are buffered with FIFO_CNT=4; word 6 is dropped and OVERFLOW=1;
   - bytes transmitted in order 01,00,02,00,...,05,00, with 1 idle clock between frames.
5. Assert RESET during DATA of byte 0 of 0xBEEF -> TX=1, TX_BUSY=0, FIFO_CNT=0, OVERFLOW=0 at that edge.
   - Then set IO64_OUT=0xBEEF -> full new frame EF, BE.
6. FIFO_CNT=2, FSM idle, new change on the pop edge -> FIFO_CNT stays 2; the transmit order matches the arrival order.

Source files
------------

// File: rtl/io64_uart_tx_if.sv
// io64_uart_tx_if: CPU output-port word in, UART line and FIFO status out
interface io64_uart_tx_if #(parameter int ADDR_W = 2);
  logic [15:0] IO64_OUT;
  logic TX;
  logic TX_BUSY;
  logic [ADDR_W:0] FIFO_CNT;
  logic OVERFLOW;
  modport master (output IO64_OUT, input TX, TX_BUSY, FIFO_CNT, OVERFLOW);
  modport slave (input IO64_OUT, output TX, TX_BUSY, FIFO_CNT, OVERFLOW);
endinterface

// File: rtl/io64_uart_tx.sv
// io64_uart_tx: buffers every change of IO64_OUT and sends it as two 8N1 UART bytes, low byte first
module io64_uart_tx #(
  parameter int CLK_DIV = 16,
  parameter int DEPTH = 4,
  parameter int ADDR_W = 2
) (
  input logic CLK,
  input logic RESET,
  io64_uart_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] L_LAST = 16'(CLK_DIV - 1);
  localparam logic [ADDR_W:0] L_FULL = (ADDR_W + 1)'(DEPTH);
  state_t r_state, w_nx;
  logic [15:0] r_prev, r_hold, r_baud, w_baud_nx;
  logic [15:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wp, r_rp;
  logic [ADDR_W:0] r_cnt;
  logic [2:0] r_bit, w_bit_nx;
  logic [7:0] w_cur;
  logic r_byte, w_byte_nx, r_tx, w_tx_nx, r_ovf, w_chg, w_push, w_pop, w_last;
  assign w_chg = bus.IO64_OUT != r_prev;
  assign w_push = w_chg && r_cnt != L_FULL;
  // pop sees only the registered count, so a word is never popped on its push edge
  assign w_pop = r_state == IDLE && r_cnt != '0;
  assign w_last = r_baud == L_LAST;
  assign w_cur = r_byte ? r_hold[15:8] : r_hold[7:0];
  assign bus.TX = r_tx;
  assign bus.TX_BUSY = r_state != IDLE;
  assign bus.FIFO_CNT = r_cnt;
  assign bus.OVERFLOW = r_ovf;
  always_comb begin
    w_nx = r_state;
    w_bit_nx = r_bit;
    w_byte_nx = r_byte;
    w_baud_nx = r_state == IDLE ? 16'd0 : w_last ? 16'd0 : r_baud + 16'd1;
    case (r_state)
      IDLE: if (w_pop) begin
        w_nx = START;
        w_byte_nx = 1'b0;
      end
      START: if (w_last) begin
        w_nx = DATA;
        w_bit_nx = 3'd0;
      end
      DATA: if (w_last) begin
        w_bit_nx = r_bit + 3'd1;
        w_nx = r_bit == 3'd7 ? STOP : DATA;
      end
      STOP: if (w_last) begin
        w_byte_nx = 1'b1;
        w_nx = r_byte ? IDLE : START;
      end
      default: w_nx = IDLE;
    endcase
    // TX is registered from the next state so the line changes cleanly on the edge
    w_tx_nx = w_nx == START ? 1'b0 : w_nx == DATA ? w_cur[w_bit_nx] : 1'b1;
  end
  always_ff @(posedge CLK)
    if (w_push) r_mem[r_wp] <= bus.IO64_OUT;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_prev <= '0;
      r_hold <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_bit <= '0;
      r_baud <= '0;
      r_byte <= 1'b0;
      r_tx <= 1'b1;
    end else begin
      r_state <= w_nx;
      r_bit <= w_bit_nx;
      r_byte <= w_byte_nx;
      r_baud <= w_baud_nx;
      r_tx <= w_tx_nx;
      if (w_chg) r_prev <= bus.IO64_OUT;
      if (w_chg && !w_push) r_ovf <= 1'b1;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_hold <= r_mem[r_rp];
        r_rp <= r_rp + 1'b1;
      end
      r_cnt <= w_push && !w_pop ? r_cnt + 1'b1 : !w_push && w_pop ? r_cnt - 1'b1 : r_cnt;
    end
  end
endmodule

// File: tb/tb_io64_uart_tx.sv
// tb_io64_uart_tx: directed stimulus queues expected bytes; a UART decoder pops and compares each frame
module tb_io64_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];
  bit abort = 1'b0;
  io64_uart_tx_if #(.ADDR_W(2)) bus ();
  io64_uart_tx #(.CLK_DIV(4), .DEPTH(4), .ADDR_W(2)) dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    q.push_back(w[7:0]);
    q.push_back(w[15:8]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bus.TX_BUSY !== 1'b0 || bus.FIFO_CNT !== 3'd0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk({name, "_timeout"}, n, 0);
  endtask

  initial begin : monitor
    logic [7:0] d;
    logic st, sb;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.TX === 1'b0) begin
        @(negedge clk);
        st = bus.TX;
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clk);
          d[b] = bus.TX;
        end
        repeat (4) @(negedge clk);
        sb = bus.TX;
        if (abort) abort = 1'b0;
        else if (q.size() == 0) chk("unexpected_frame", int'(d), -1);
        else begin
          e = q.pop_front();
          chk("frame", int'({st, sb, d}), int'({1'b0, 1'b1, e}));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, lows, g;
    bus.IO64_OUT = 16'h0000;
    repeat (3) tick();
    chk("rst_tx", bus.TX, 1);
    chk("rst_busy", bus.TX_BUSY, 0);
    chk("rst_cnt", bus.FIFO_CNT, 0);
    chk("rst_ovf", bus.OVERFLOW, 0);
    @(negedge clk) rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.TX !== 1'b1 || bus.TX_BUSY !== 1'b0 || bus.FIFO_CNT !== 3'd0) lows++;
    end
    chk("idle_hold", lows, 0);

    @(negedge clk) bus.IO64_OUT = 16'h1234;
    push_word(16'h1234);
    tick();
    chk("push_cnt", bus.FIFO_CNT, 1);
    chk("push_tx_high", bus.TX, 1);
    tick();
    chk("pop_tx_low", bus.TX, 0);
    chk("pop_busy", bus.TX_BUSY, 1);
    chk("pop_cnt", bus.FIFO_CNT, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.TX_BUSY === 1'b1 && n < 300);
    chk("busy_len", n, 80);
    wait_idle("t2");

    @(negedge clk) bus.IO64_OUT = 16'h00AB;
    push_word(16'h00AB);
    repeat (10) @(negedge clk);
    bus.IO64_OUT = 16'h00AB;
    wait_idle("t3");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.TX_BUSY !== 1'b0) n++;
    end
    chk("no_repeat_frame", n, 0);

    for (int v = 1; v <= 6; v++) begin
      @(negedge clk) bus.IO64_OUT = 16'(v);
      if (v <= 5) push_word(16'(v));
      tick();
      if (v == 5) begin
        chk("full_cnt", bus.FIFO_CNT, 4);
        chk("full_ovf", bus.OVERFLOW, 0);
      end
      if (v == 6) begin
        chk("drop_cnt", bus.FIFO_CNT, 4);
        chk("drop_ovf", bus.OVERFLOW, 1);
      end
    end
    n = 0;
    while (bus.TX_BUSY === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    g = 0;
    do begin
      tick();
      g++;
    end while (bus.TX_BUSY === 1'b0 && g < 50);
    chk("gap_clocks", g, 1);
    wait_idle("t4");
    chk("ovf_sticky", bus.OVERFLOW, 1);

    @(negedge clk) bus.IO64_OUT = 16'h0101;
    push_word(16'h0101);
    repeat (5) @(negedge clk);
    bus.IO64_OUT = 16'h0202;
    push_word(16'h0202);
    repeat (5) @(negedge clk);
    bus.IO64_OUT = 16'h0303;
    push_word(16'h0303);
    tick();
    n = 0;
    while (bus.TX_BUSY === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("idle_cnt2", bus.FIFO_CNT, 2);
    bus.IO64_OUT = 16'h0404;
    push_word(16'h0404);
    tick();
    chk("pushpop_cnt", bus.FIFO_CNT, 2);
    chk("pushpop_busy", bus.TX_BUSY, 1);
    wait_idle("t6");

    @(negedge clk) bus.IO64_OUT = 16'hBEEF;
    push_word(16'hBEEF);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    bus.IO64_OUT = 16'h0000;
    abort = 1'b1;
    q.delete();
    tick();
    chk("midrst_tx", bus.TX, 1);
    chk("midrst_busy", bus.TX_BUSY, 0);
    chk("midrst_cnt", bus.FIFO_CNT, 0);
    chk("midrst_ovf", bus.OVERFLOW, 0);
    @(negedge clk) rst = 1'b0;
    repeat (60) @(negedge clk);
    bus.IO64_OUT = 16'hBEEF;
    push_word(16'hBEEF);
    tick();
    wait_idle("t5");
    repeat (20) tick();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
